instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Purpose: turns op requests (op select plus register, immediate and target
// fields) into 32-bit MIPS-style instruction words. The words are buffered in
// a DEPTH-entry FIFO and streamed out with a word address. The address starts
// at BASE_ADDR and advances by 4 on every word that is consumed.
//
// Optional feature: define INSTR_ENC_UNSUPPORTED_TRAP_EN to drop ops 28-31
// instead of enqueuing them. Each drop pulses err_unsupported for one cycle.
// Without the macro these ops are enqueued as 32'h00000000 and
// err_unsupported stays 0.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   in_op               op select 0..31
//   in_rs, in_rt, in_rd, in_shamt, in_imm, in_target   instruction fields
//   out_valid/out_ready encoded-word handshake
//   out_instr           FIFO head word (0 while empty)
//   out_addr            word address paired with out_instr
//   fill_level          FIFO occupancy 0..DEPTH
//   err_unsupported     one-cycle pulse on a dropped unsupported op
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_op,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_shamt,
    input  logic [15:0]              in_imm,
    input  logic [25:0]              in_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_addr,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     err_unsupported
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [31:0]      enc_word;

    // Instruction word assembly. Fields that an op does not use are forced to
    // zero, so the words look the same as those from a standard assembler.
    function automatic logic [31:0] encode(
        input logic [4:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [5:0]  code;
        logic [4:0]  rs_f;
        logic [4:0]  rt_f;
        logic [4:0]  rd_f;
        logic [4:0]  sh_f;
        logic [31:0] word;
        code = 6'b000000;
        rs_f = rs;
        rt_f = rt;
        rd_f = rd;
        sh_f = 5'd0;
        word = 32'h0000_0000;
        // code is the funct field for R-type ops and the opcode otherwise
        case (op)
            5'd0:  code = 6'b100000;
            5'd1:  code = 6'b100001;
            5'd2:  code = 6'b100010;
            5'd3:  code = 6'b100011;
            5'd4:  code = 6'b100100;
            5'd5:  code = 6'b100101;
            5'd6:  code = 6'b100110;
            5'd7:  code = 6'b100111;
            5'd8:  code = 6'b101010;
            5'd9:  code = 6'b000000;
            5'd10: code = 6'b000010;
            5'd11: code = 6'b000011;
            5'd12: code = 6'b000100;
            5'd13: code = 6'b000110;
            5'd14: code = 6'b000111;
            5'd15: code = 6'b001000;
            5'd16: code = 6'b001000;
            5'd17: code = 6'b001001;
            5'd18: code = 6'b001100;
            5'd19: code = 6'b001101;
            5'd20: code = 6'b001110;
            5'd21: code = 6'b100011;
            5'd22: code = 6'b101011;
            5'd23: code = 6'b000100;
            5'd24: code = 6'b000101;
            5'd25: code = 6'b000010;
            5'd26: code = 6'b000011;
            default: code = 6'b000000;
        endcase
        if (op <= 5'd15) begin
            // immediate shifts use shamt and have no rs; JR uses rs only
            if (op >= 5'd9 && op <= 5'd11) begin
                rs_f = 5'd0;
                sh_f = shamt;
            end
            if (op == 5'd15) begin
                rt_f = 5'd0;
                rd_f = 5'd0;
            end
            word = {6'b000000, rs_f, rt_f, rd_f, sh_f, code};
        end else if (op <= 5'd24) begin
            word = {code, rs, rt, imm};
        end else if (op <= 5'd26) begin
            word = {code, target};
        end else begin
            word = 32'h0000_0000;
        end
        return word;
    endfunction

    assign enc_word   = encode(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign in_ready   = !full && !reset;
    assign accept     = in_valid && in_ready;
    assign out_valid  = !empty;
    assign pop        = out_valid && out_ready;
    assign out_instr  = empty ? 32'h0000_0000 : mem[rd_ptr];
    assign fill_level = count;

`ifdef INSTR_ENC_UNSUPPORTED_TRAP_EN
    logic unsupported;
    logic err_p1;

    assign unsupported     = (in_op >= 5'd28);
    assign push            = accept && !unsupported;
    assign err_unsupported = err_p1;

    // --- stage p1: error pulse one cycle after the dropped request ---
    always_ff @(posedge clock) begin
        if (reset) begin
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= accept && unsupported;
        end
    end
`else
    assign push            = accept;
    assign err_unsupported = 1'b0;
`endif

    // --- FIFO storage: data only, so it has no reset ---
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    // --- FIFO control and address counter ---
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= BASE_ADDR;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_addr <= out_addr + 32'd4;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
